// File: rtl/frame_ctrl_if.sv
// frame_ctrl_if: request/window-move bundle between the decode/control unit
// and the frame controller.
//   master : decode/control side - drives Call, Rtn, Frame_Size, Ret_PC_In
//   slave  : frame controller    - drives New_FP, FP_move, FP_push_up,
//            Ret_PC_Out, Ret_Valid, Busy, Fault, Depth
interface frame_ctrl_if #(
  parameter int ADDR_W = 4,
  parameter int PC_W   = 16
);
  logic              Call;
  logic              Rtn;
  logic [2:0]        Frame_Size;
  logic [PC_W-1:0]   Ret_PC_In;
  logic [ADDR_W-1:0] New_FP;
  logic              FP_move;
  logic              FP_push_up;
  logic [PC_W-1:0]   Ret_PC_Out;
  logic              Ret_Valid;
  logic              Busy;
  logic              Fault;
  logic [2:0]        Depth;

  modport master (
    output Call, Rtn, Frame_Size, Ret_PC_In,
    input  New_FP, FP_move, FP_push_up, Ret_PC_Out, Ret_Valid, Busy, Fault, Depth
  );

  modport slave (
    input  Call, Rtn, Frame_Size, Ret_PC_In,
    output New_FP, FP_move, FP_push_up, Ret_PC_Out, Ret_Valid, Busy, Fault, Depth
  );
endinterface

// File: rtl/frame_ctrl.sv
// frame_ctrl: call/return frame controller for the windowed register file.
// Holds the frame pointer, translates logical register numbers to physical
// addresses, and keeps a return stack of (return PC, frame shift) pairs so a
// RTN restores FP exactly.
// Ports:
//   Clock, Reset        : clock, asynchronous active-high reset
//   bus (slave)         : Call/Rtn requests in; window-move and status out
//   Log_Rd/Log_Rs/Log_Rm: logical register numbers
//   Rd/Rs/Rm_Addr       : physical addresses = FP + logical number
module frame_ctrl #(
  parameter int ADDR_W    = 4,
  parameter int WIN_W     = 3,
  parameter int PC_W      = 16,
  parameter int RAS_DEPTH = 4
) (
  input  logic              Clock,
  input  logic              Reset,
  frame_ctrl_if.slave       bus,
  input  logic [WIN_W-1:0]  Log_Rd,
  input  logic [WIN_W-1:0]  Log_Rs,
  input  logic [WIN_W-1:0]  Log_Rm,
  output logic [ADDR_W-1:0] Rd_Addr,
  output logic [ADDR_W-1:0] Rs_Addr,
  output logic [ADDR_W-1:0] Rm_Addr
);

  localparam int CNT_W  = 4;
  localparam int IDX_W  = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  // Highest FP that still leaves a full window inside the register file.
  localparam int FP_MAX = (2 ** ADDR_W) - (2 ** WIN_W);

  typedef enum logic [1:0] {IDLE, MOVE, SETTLE, FAULT} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] fp_q;
  logic [ADDR_W-1:0] new_fp_q, new_fp_d;
  logic              move_q, move_d;
  logic              up_q, up_d;
  logic [PC_W-1:0]   ret_pc_q, ret_pc_d;
  logic              valid_q, valid_d;
  logic [CNT_W-1:0]  depth_q;
  logic              push, pop, fp_load;

  logic [PC_W-1:0]   stk_pc [RAS_DEPTH];
  logic [2:0]        stk_sz [RAS_DEPTH];

  logic [IDX_W-1:0]  push_idx, top_idx;
  logic [ADDR_W:0]   call_sum;
  logic              call_bad;

  assign push_idx = IDX_W'(depth_q);
  assign top_idx  = IDX_W'(depth_q - 1'b1);
  assign call_sum = {1'b0, fp_q} + (ADDR_W + 1)'(bus.Frame_Size);
  assign call_bad = (call_sum > (ADDR_W + 1)'(FP_MAX)) || (depth_q == CNT_W'(RAS_DEPTH));

  always_comb begin
    state_d  = state_q;
    new_fp_d = new_fp_q;
    move_d   = 1'b0;
    up_d     = up_q;
    ret_pc_d = ret_pc_q;
    valid_d  = 1'b0;
    push     = 1'b0;
    pop      = 1'b0;
    fp_load  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.Call && bus.Rtn) begin
          state_d = FAULT;
        end else if (bus.Call) begin
          if (call_bad) begin
            state_d = FAULT;
          end else begin
            state_d  = MOVE;
            push     = 1'b1;
            move_d   = 1'b1;
            up_d     = 1'b1;
            new_fp_d = call_sum[ADDR_W-1:0];
          end
        end else if (bus.Rtn) begin
          if (depth_q == '0) begin
            state_d = FAULT;
          end else begin
            state_d  = MOVE;
            pop      = 1'b1;
            move_d   = 1'b1;
            up_d     = 1'b0;
            new_fp_d = fp_q - ADDR_W'(stk_sz[top_idx]);
            ret_pc_d = stk_pc[top_idx];
            valid_d  = 1'b1;
          end
        end
      end
      MOVE: begin
        state_d = SETTLE;
        fp_load = 1'b1;
      end
      SETTLE:  state_d = IDLE;
      FAULT:   state_d = FAULT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      fp_q     <= '0;
      new_fp_q <= '0;
      move_q   <= 1'b0;
      up_q     <= 1'b0;
      ret_pc_q <= '0;
      valid_q  <= 1'b0;
      depth_q  <= '0;
    end else begin
      state_q  <= state_d;
      new_fp_q <= new_fp_d;
      move_q   <= move_d;
      up_q     <= up_d;
      ret_pc_q <= ret_pc_d;
      valid_q  <= valid_d;
      if (fp_load) fp_q <= new_fp_q;
      if (push)      depth_q <= depth_q + 1'b1;
      else if (pop)  depth_q <= depth_q - 1'b1;
    end
  end

  // Stack contents need no reset: Depth alone defines which entries are live.
  always_ff @(posedge Clock) begin
    if (push) begin
      stk_pc[push_idx] <= bus.Ret_PC_In;
      stk_sz[push_idx] <= bus.Frame_Size;
    end
  end

  assign Rd_Addr = fp_q + ADDR_W'(Log_Rd);
  assign Rs_Addr = fp_q + ADDR_W'(Log_Rs);
  assign Rm_Addr = fp_q + ADDR_W'(Log_Rm);

  assign bus.New_FP     = new_fp_q;
  assign bus.FP_move    = move_q;
  assign bus.FP_push_up = up_q;
  assign bus.Ret_PC_Out = ret_pc_q;
  assign bus.Ret_Valid  = valid_q;
  assign bus.Busy       = (state_q != IDLE);
  assign bus.Fault      = (state_q == FAULT);
  // Depth port is 3 bits; a full 8-deep stack reads back as 7.
  assign bus.Depth      = (depth_q > CNT_W'(7)) ? 3'd7 : depth_q[2:0];

endmodule

// File: doc/frame_ctrl.md
Name: frame_ctrl

Overview:
- Call/return frame controller that drives the FP-window side of the windowed register file: New_FP, FP_move, FP_push_up and the physical register addresses.
- Holds the current frame pointer and translates 3-bit logical register numbers into 4-bit physical addresses.
- Keeps a return stack of (return PC, frame shift) pairs so that RTN restores FP exactly.
- Sits between the decode/control unit and the register file; it is the initiator of every window move.

Parameters:
- ADDR_W, 4, physical register address width (16 physical registers).
- WIN_W, 3, logical register number width (8-register window).
- PC_W, 16, return PC width.
- RAS_DEPTH, 4, return stack entries (2 to 8).

Ports:
- Clock  in  1  system clock; all state changes on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Call  in  1  CALL request, sampled only in IDLE.
- Rtn  in  1  RTN request, sampled only in IDLE.
- Frame_Size  in  3  window shift I for Call.
- Ret_PC_In  in  PC_W  return PC pushed on Call.
- Log_Rd, Log_Rs, Log_Rm  in  WIN_W each  logical register numbers.
- Rd_Addr, Rs_Addr, Rm_Addr  out  ADDR_W each  physical addresses = FP + logical number.
- New_FP  out  ADDR_W  target frame pointer.
- FP_move  out  1  one-cycle window-move strobe.
- FP_push_up  out  1  1 = Call (FP increases), 0 = Rtn.
- Ret_PC_Out  out  PC_W  popped return PC.
- Ret_Valid  out  1  one-cycle strobe qualifying Ret_PC_Out.
- Busy  out  1  high while a move is in progress.
- Fault  out  1  sticky error flag.
- Depth  out  3  number of occupied stack entries.

Behaviour:
- Reset (asynchronous, any state, including mid-move):
  - FP=0; state IDLE; stack emptied (Depth=0).
  - New_FP=0, FP_move=0, FP_push_up=0, Ret_PC_Out=0, Ret_Valid=0, Busy=0, Fault=0.
  - A move in flight is abandoned and not completed.
- Address translation: combinational from the registered FP. Rd_Addr = FP + Log_Rd, zero-extended 4-bit add; likewise for Rs and Rm. Wrap cannot occur because FP ≤ 8 is guaranteed by the Call check.
- States:
  - IDLE: Busy=0. Priority when Call/Rtn are seen (checked at the edge):
    - Call and Rtn both high: go to FAULT.
    - Call with FP + Frame_Size > 8 (5-bit compare), or Depth = RAS_DEPTH: go to FAULT.
    - Rtn with Depth = 0: go to FAULT.
    - Otherwise go to MOVE.
  - MOVE: lasts exactly one cycle, entered on the edge after the request; all outputs are registered.
    - Call: FP_move=1, FP_push_up=1, New_FP = FP + Frame_Size. Push {Ret_PC_In, Frame_Size} on the request edge; Depth increments on that edge.
    - Rtn: pop top entry (size I, pc) on the request edge; Depth decrements. FP_move=1, FP_push_up=0, New_FP = FP − I, Ret_PC_Out = pc, Ret_Valid=1.
    - FP takes New_FP on the MOVE→SETTLE edge.
    - Busy=1.
  - SETTLE: one cycle; Busy=1, FP_move=0, Ret_Valid=0. Covers the register file's read-window reload. Then returns to IDLE.
  - FAULT: sticky until Reset.
    - Fault=1, Busy=1, FP_move=0.
    - FP, stack and Depth frozen at their pre-request values; no push or pop occurs.
    - Call/Rtn ignored.
- Request timing:
  - Request at edge N gives FP_move high during cycle N+1, new FP visible on Rd/Rs/Rm_Addr from N+2, and IDLE again at N+3.
  - Minimum spacing between accepted requests is 3 cycles.
- Call/Rtn asserted while Busy are dropped silently. No queueing; the caller must hold or re-issue.
- Frame_Size=0 on Call is legal: FP_move pulses with New_FP = FP, and an entry is still pushed.
- Boundary: FP + Frame_Size = 8 is accepted (window covers registers 8..15); 9 faults.
- Stack is LIFO with a pointer, no wrap; full and empty are handled as faults above.
- FP_push_up is meaningful only while FP_move=1; it is held at its last value otherwise.

Test Plan:
- Reset mid-MOVE → next cycle FP=0, Depth=0, FP_move=0, Busy=0, Fault=0; Rd_Addr = Log_Rd.
- From reset, Call Frame_Size=3 Ret_PC_In=0x0120 at edge N → cycle N+1: FP_move=1, FP_push_up=1, New_FP=3; Depth=1. Then Log_Rd=5 gives Rd_Addr=8 from N+2; Busy=0 at N+3.
- After the Call above, Rtn → FP_move=1, FP_push_up=0, New_FP=0, Ret_Valid=1, Ret_PC_Out=0x0120; Depth=0; Rd_Addr=5 afterwards.
- FP=5, Call Frame_Size=3 → accepted, New_FP=8. Then Call Frame_Size=1 → Fault=1, FP stays 8, Depth unchanged, no FP_move.
- Four nested Calls (sizes 1,1,1,1) fill RAS_DEPTH=4 → fifth Call faults. Separately, Rtn at Depth=0 faults, and Call+Rtn in the same cycle faults.
- Call held high for 5 cycles → exactly one push and one FP_move per accepted request (requests at N and N+3), none during Busy.
